// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: NOP encoding, fetch state encoding, opcode field values.
// Combinational helpers only; no state.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_READY = 2'd0,
        FETCH_BUSY  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    // instr[6:2] values as seen on id_opcode
    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[6:2];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// IF/ID register plus one skid entry; push/pop/flush, program order preserved.
// Latency: push visible on id_* the next cycle when IF/ID is free, else via skid.
// Backpressure: never refuses a push; the caller keeps occupancy plus outstanding at most 2.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [31:0]     push_instr_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [1:0]      occupancy_o
);

    logic            id_valid_q, id_valid_d, skid_valid_q, skid_valid_d;
    logic [31:0]     id_instr_q, id_instr_d, skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d, skid_pc_q, skid_pc_d;
    logic            pop;

    assign pop = id_valid_q & id_ready_i;

    always_comb begin
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            id_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop && skid_valid_q) begin
            id_valid_d   = 1'b1;
            id_instr_d   = skid_instr_q;
            id_pc_d      = skid_pc_q;
            skid_valid_d = push_i;
            if (push_i) begin
                skid_instr_d = push_instr_i;
                skid_pc_d    = push_pc_i;
            end
        end else if (pop || !id_valid_q) begin
            id_valid_d = push_i;
            if (push_i) begin
                id_instr_d = push_instr_i;
                id_pc_d    = push_pc_i;
            end
        end else if (push_i) begin
            // IF/ID held by decode: the word waits behind it
            skid_valid_d = 1'b1;
            skid_instr_d = push_instr_i;
            skid_pc_d    = push_pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign id_valid_o  = id_valid_q;
    assign id_instr_o  = id_instr_q;
    assign id_pc_o     = id_pc_q;
    assign occupancy_o = {1'b0, id_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, one outstanding imem read, two-entry IF/ID buffer.
// Latency: request at N gives id_valid at N+L+1; one instruction per cycle when L=1.
// Backpressure: stops requesting once buffered plus outstanding would exceed 2; redirect flushes.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_opcode
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, redirect_tgt;
    logic [1:0]      occupancy, committed;
    logic            consume, rsp_done, issue, push;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign consume      = id_valid & id_ready;
    assign rsp_done     = (state_q == FETCH_BUSY) && imem_rvalid;
    assign committed    = occupancy + {1'b0, state_q != FETCH_READY};
    // rst_n gate keeps the request low while reset is held
    assign issue = rst_n && !redirect_valid
                && (state_q == FETCH_READY || rsp_done)
                && ((committed - {1'b0, consume}) <= 2'd1);
    assign push      = rsp_done && !redirect_valid;
    assign imem_req  = issue;
    assign imem_addr = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_tgt;
            if (state_q != FETCH_READY) begin
                state_d = imem_rvalid ? FETCH_READY : FETCH_DRAIN;
            end
        end else begin
            if (imem_rvalid && state_q != FETCH_READY) begin
                state_d = FETCH_READY;
            end
            if (issue) begin
                state_d  = FETCH_BUSY;
                pc_d     = pc_q + XLEN'(4);
                req_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH_READY;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_buffer #(.XLEN(XLEN)) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_instr_i (imem_rdata),
        .push_pc_i    (req_pc_q),
        .id_ready_i   (id_ready),
        .id_valid_o   (id_valid),
        .id_instr_o   (id_instr),
        .id_pc_o      (id_pc),
        .occupancy_o  (occupancy)
    );

    assign id_opcode = opcode_of(id_instr);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with variable latency plus program-order scoreboard.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic [4:0]  id_opcode;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1;

    // memory model: at most one request pending
    bit          pend_vld = 0;
    logic [31:0] pend_addr = '0;
    int          pend_due = 0;

    // reference: next request address, next delivered pc, words owned by the fetch stage
    logic [31:0] exp_req = RST_PC, exp_pc = RST_PC;
    int          inflight = 0;

    // per-cycle observations and the expectations in force for that cycle
    bit          o_req, o_vld, o_take, o_ovl, o_redir;
    logic [31:0] o_addr, o_pc, o_instr, e_addr, e_pc;
    logic [4:0]  o_opc;
    int          o_cyc;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        if (!rst_n) begin
            pend_vld = 0;
            exp_req  = RST_PC;
            exp_pc   = RST_PC;
            inflight = 0;
        end
        imem_rvalid = pend_vld && (cyc >= pend_due);
        imem_rdata  = imem_rvalid ? memword(pend_addr) : $urandom;
        #1;
        o_cyc   = cyc;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_vld   = id_valid;
        o_take  = id_valid && id_ready;
        o_pc    = id_pc;
        o_instr = id_instr;
        o_opc   = id_opcode;
        o_redir = redirect_valid;
        o_ovl   = imem_req && pend_vld && !imem_rvalid;
        e_pc    = exp_pc;
        e_addr  = exp_req;
        if (o_take) begin
            exp_pc = exp_pc + 32'd4;
            inflight--;
        end
        if (imem_rvalid) pend_vld = 0;
        if (o_req) begin
            exp_req   = exp_req + 32'd4;
            inflight++;
            pend_vld  = 1;
            pend_addr = o_addr;
            pend_due  = cyc + int'($urandom_range(lat_max, lat_min));
        end
        if (redirect_valid && rst_n) begin
            exp_req  = redirect_pc & ~32'h3;
            exp_pc   = exp_req;
            inflight = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        rst_n = 0; id_ready = 1; redirect_valid = 0; lat_min = 1; lat_max = 1;
        repeat (2) step();
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_req); end
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", o_vld); end
        checks++; if (o_instr !== NOP) begin errors++; $display("FAIL reset_id_instr: got %h want %h", o_instr, NOP); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", o_pc); end
        checks++; if (o_opc !== 5'b00100) begin errors++; $display("FAIL reset_opcode: got %b want 00100", o_opc); end
        checks++; if (o_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", o_addr, RST_PC); end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            a = RST_PC + 32'(4 * i);
            checks++; if (o_req !== 1'b1 || o_addr !== a) begin errors++; $display("FAIL boot_req%0d: got req=%b addr=%h want req=1 addr=%h", i, o_req, o_addr, a); end
            checks++; if (o_vld !== (i == 2)) begin errors++; $display("FAIL boot_valid%0d: got %b want %b", i, o_vld, i == 2); end
        end
        checks++; if (o_pc !== RST_PC || o_instr !== memword(RST_PC)) begin errors++; $display("FAIL boot_first: got pc=%h instr=%h want pc=%h instr=%h", o_pc, o_instr, RST_PC, memword(RST_PC)); end
    endtask

    task automatic test_backpressure();
        repeat (3) step();
        id_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req_stop%0d: got %b want 0", i, o_req); end
            checks++; if (inflight > 2 || o_vld !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got inflight=%0d valid=%b want <=2 and 1", i, inflight, o_vld); end
        end
        id_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (o_req !== 1'b1 || o_vld !== 1'b1) begin errors++; $display("FAIL bp_resume%0d: got req=%b valid=%b want 1 1", i, o_req, o_vld); end
            checks++; if (o_pc !== e_pc || o_instr !== memword(e_pc)) begin errors++; $display("FAIL bp_order%0d: got pc=%h instr=%h want pc=%h instr=%h", i, o_pc, o_instr, e_pc, memword(e_pc)); end
        end
    endtask

    task automatic test_redirect_busy();
        int drain_cyc, req_cyc;
        bit seen_req, seen_vld;
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_req) break;
        end
        redirect_valid = 1; redirect_pc = 32'h0000_0203;
        drain_cyc = pend_due;
        step();
        redirect_valid = 0;
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL rb_no_issue: got %b want 0", o_req); end
        seen_req = 0; seen_vld = 0; req_cyc = 0;
        for (int i = 0; i < 20 && !seen_vld; i++) begin
            step();
            if (i == 0) begin
                checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL rb_flush: got id_valid=%b want 0", o_vld); end
            end
            if (o_req && !seen_req) begin
                seen_req = 1; req_cyc = o_cyc;
                checks++; if (o_addr !== 32'h200 || o_cyc !== drain_cyc + 1) begin errors++; $display("FAIL rb_req: got addr=%h cyc=%0d want addr=200 cyc=%0d", o_addr, o_cyc, drain_cyc + 1); end
            end
            if (o_vld) begin
                seen_vld = 1;
                checks++; if (o_pc !== 32'h200 || o_instr !== memword(32'h200) || o_cyc !== req_cyc + 4) begin errors++; $display("FAIL rb_first: got pc=%h instr=%h cyc=%0d want pc=200 instr=%h cyc=%0d", o_pc, o_instr, o_cyc, memword(32'h200), req_cyc + 4); end
            end
        end
        checks++; if (!seen_vld) begin errors++; $display("FAIL rb_timeout: got no id_valid want one within 20 cycles"); end
    endtask

    task automatic test_redirect_rvalid();
        logic [31:0] w;
        bit seen_vld;
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            if (pend_vld && cyc >= pend_due) break;
            step();
        end
        w = pend_addr;
        redirect_valid = 1; redirect_pc = 32'h0000_0300;
        step();
        redirect_valid = 0;
        step();
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL rr_flush: got id_valid=%b want 0", o_vld); end
        checks++; if (o_req !== 1'b1 || o_addr !== 32'h300) begin errors++; $display("FAIL rr_req: got req=%b addr=%h want 1 300", o_req, o_addr); end
        seen_vld = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_vld && o_pc === w) begin
                checks++; errors++; $display("FAIL rr_dropped: got pc=%h on id_* want never", o_pc);
            end
            if (o_vld && !seen_vld) begin
                seen_vld = 1;
                checks++; if (o_pc !== 32'h300 || o_instr !== memword(32'h300)) begin errors++; $display("FAIL rr_first: got pc=%h instr=%h want pc=300 instr=%h", o_pc, o_instr, memword(32'h300)); end
            end
        end
        checks++; if (!seen_vld) begin errors++; $display("FAIL rr_timeout: got no id_valid want one"); end
    endtask

    task automatic test_redirect_drain();
        bit seen_req, seen_vld;
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_req) break;
        end
        redirect_valid = 1; redirect_pc = 32'h0000_0400;
        step();
        redirect_pc = 32'h0000_0500;
        step();
        redirect_valid = 0;
        seen_req = 0; seen_vld = 0;
        for (int i = 0; i < 24 && !seen_vld; i++) begin
            step();
            if (o_req && !seen_req) begin
                seen_req = 1;
                checks++; if (o_addr !== 32'h500) begin errors++; $display("FAIL rd_req: got addr=%h want 500", o_addr); end
            end
            if (o_vld) begin
                seen_vld = 1;
                checks++; if (o_pc !== 32'h500 || o_instr !== memword(32'h500)) begin errors++; $display("FAIL rd_first: got pc=%h instr=%h want pc=500 instr=%h", o_pc, o_instr, memword(32'h500)); end
            end
        end
        checks++; if (!seen_vld) begin errors++; $display("FAIL rd_timeout: got no id_valid want one"); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] a;
        lat_min = 1; lat_max = 1;
        repeat (6) step();
        rst_n = 0;
        #2;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mr_async: got valid=%b req=%b want 0 0", id_valid, imem_req); end
        checks++; if (id_instr !== NOP || id_opcode !== 5'b00100) begin errors++; $display("FAIL mr_nop: got instr=%h op=%b want %h 00100", id_instr, id_opcode, NOP); end
        repeat (2) step();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            a = RST_PC + 32'(4 * i);
            checks++; if (o_req !== 1'b1 || o_addr !== a) begin errors++; $display("FAIL mr_req%0d: got req=%b addr=%h want 1 %h", i, o_req, o_addr, a); end
        end
        checks++; if (o_vld !== 1'b1 || o_pc !== RST_PC) begin errors++; $display("FAIL mr_first: got valid=%b pc=%h want 1 %h", o_vld, o_pc, RST_PC); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int ndeliv;
        ndeliv = 0;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 500; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : ($urandom & 32'h0000_FFFF);
            step();
            if (o_req) begin
                checks++; if (o_addr !== e_addr || o_redir) begin errors++; $display("FAIL rnd_req: got addr=%h redir=%b want addr=%h redir=0", o_addr, o_redir, e_addr); end
            end
            if (o_take) begin
                ndeliv++;
                w = memword(e_pc);
                checks++; if (o_pc !== e_pc || o_instr !== w || o_opc !== w[6:2]) begin errors++; $display("FAIL rnd_deliver: got pc=%h instr=%h op=%b want pc=%h instr=%h op=%b", o_pc, o_instr, o_opc, e_pc, w, w[6:2]); end
            end
            if (inflight > 2 || o_ovl) begin
                checks++; errors++; $display("FAIL rnd_capacity: got inflight=%0d overlap=%b want <=2 and 0", inflight, o_ovl);
            end
        end
        redirect_valid = 0;
        checks++; if (ndeliv < 50) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >=50", ndeliv); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect_busy();
        test_redirect_rvalid();
        test_redirect_drain();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
